// File: rtl/dwt_subband_reorder_if.sv
// Coefficient-pair input and reordered-coefficient output of the subband reorder buffer.
// The master modport is the upstream/downstream environment; the slave modport is the reorder block.
interface dwt_subband_reorder_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] low_i;
   logic [DATA_W-1:0] high_i;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_band;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              frame_done;

   modport master (
      output low_i, high_i, in_valid, out_ready,
      input  in_ready, out_data, out_band, out_valid, out_last, frame_done
   );

   modport slave (
      input  low_i, high_i, in_valid, out_ready,
      output in_ready, out_data, out_band, out_valid, out_last, frame_done
   );
endinterface

// File: rtl/dwt_subband_reorder.sv
// Buffers one frame of (low, high) DWT coefficient pairs and re-emits it as all low
// coefficients followed by all high coefficients over a valid/ready stream.
module dwt_subband_reorder #(
   parameter int DATA_W    = 8,
   parameter int FRAME_LEN = 16,
   parameter int ADDR_W    = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   dwt_subband_reorder_if.slave  bus
);
   typedef enum logic [1:0] {
      FILL       = 2'd0,
      DRAIN_LOW  = 2'd1,
      DRAIN_HIGH = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   state_t              state_reg;
   state_t              state_next;
   logic [ADDR_W-1:0]   wr_idx_reg;
   logic [ADDR_W-1:0]   rd_idx_reg;
   logic                frame_done_reg;
   logic [DATA_W-1:0]   lbuf [FRAME_LEN];
   logic [DATA_W-1:0]   hbuf [FRAME_LEN];

   logic accept_in;
   logic accept_out;
   logic wr_last;
   logic rd_last;

   assign accept_in  = bus.in_valid && (state_reg == FILL);
   assign accept_out = bus.out_ready && (state_reg != FILL);
   assign wr_last    = (wr_idx_reg == LAST_IDX);
   assign rd_last    = (rd_idx_reg == LAST_IDX);

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_reg <= FILL;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         FILL:       if (accept_in && wr_last)  state_next = DRAIN_LOW;
         DRAIN_LOW:  if (accept_out && rd_last) state_next = DRAIN_HIGH;
         DRAIN_HIGH: if (accept_out && rd_last) state_next = FILL;
         default:    state_next = FILL;
      endcase
   end

   // Indices clear explicitly at each phase end so non-power-of-two frames never wrap.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         wr_idx_reg     <= '0;
         rd_idx_reg     <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         if (accept_in) begin
            wr_idx_reg <= wr_last ? '0 : wr_idx_reg + 1'b1;
         end
         if (accept_out) begin
            rd_idx_reg <= rd_last ? '0 : rd_idx_reg + 1'b1;
         end
         frame_done_reg <= (state_reg == DRAIN_HIGH) && accept_out && rd_last;
      end
   end

   // Buffer contents are deliberately not reset; sys_rst only blocks capture.
   always_ff @(posedge sys_clk) begin
      if (accept_in && sys_rst) begin
         lbuf[wr_idx_reg] <= bus.low_i;
         hbuf[wr_idx_reg] <= bus.high_i;
      end
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_band  = 1'b0;
      bus.out_last  = 1'b0;
      unique case (state_reg)
         FILL: begin
            bus.in_ready = 1'b1;
         end
         DRAIN_LOW: begin
            bus.out_valid = 1'b1;
            bus.out_data  = lbuf[rd_idx_reg];
         end
         DRAIN_HIGH: begin
            bus.out_valid = 1'b1;
            bus.out_band  = 1'b1;
            bus.out_data  = hbuf[rd_idx_reg];
            bus.out_last  = rd_last;
         end
         default: begin
            bus.in_ready = 1'b1;
         end
      endcase
   end

   assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_dwt_subband_reorder.sv
// Directed bench for dwt_subband_reorder with a 4-pair frame; each task checks its own scenario.
module tb_dwt_subband_reorder;
   logic sys_clk;
   logic sys_rst;
   int   tests;
   int   failed;

   dwt_subband_reorder_if #(.DATA_W(8)) bus ();

   dwt_subband_reorder #(
      .DATA_W   (8),
      .FRAME_LEN(4),
      .ADDR_W   (2)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus    (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Stimulus only: offers pairs start..3 with 2-bit bubble counts per pair taken from gaps.
   task automatic fill_pairs(input logic [7:0] lbase, input logic [7:0] hbase,
                             input int start, input logic [7:0] gaps);
      for (int i = start; i < 4; i++) begin
         for (int b = 0; b < int'(gaps[2*i +: 2]); b++) begin
            @(negedge sys_clk);
            bus.in_valid = 1'b0;
         end
         @(negedge sys_clk);
         bus.in_valid = 1'b1;
         bus.low_i    = lbase + 8'(i);
         bus.high_i   = hbase + 8'(i);
      end
      @(negedge sys_clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      sys_rst       = 1'b0;
      bus.in_valid  = 1'b1;
      bus.low_i     = 8'h99;
      bus.high_i    = 8'h98;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge sys_clk);
         tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
         tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
         tests++; if (bus.out_data !== 8'h00) begin failed++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
         tests++; if (bus.frame_done !== 1'b0) begin failed++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
         tests++; if ({bus.out_band, bus.out_last} !== 2'b00) begin failed++; $display("FAIL reset_band_last: got %b expected 00", {bus.out_band, bus.out_last}); end
      end
      sys_rst      = 1'b1;
      bus.in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge sys_clk);
         tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL idle_out_valid: got %b expected 0", bus.out_valid); end
      end
   endtask

   task automatic test_basic;
      logic [7:0] exp;
      fill_pairs(8'd10, 8'd20, 0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         exp = (k < 4) ? 8'(10 + k) : 8'(16 + k);
         tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid beat %0d: got %b expected 1", k, bus.out_valid); end
         tests++; if (bus.out_data !== exp) begin failed++; $display("FAIL basic_data beat %0d: got %0d expected %0d", k, bus.out_data, exp); end
         tests++; if (bus.out_band !== (k >= 4)) begin failed++; $display("FAIL basic_band beat %0d: got %b expected %b", k, bus.out_band, k >= 4); end
         tests++; if (bus.out_last !== (k == 7)) begin failed++; $display("FAIL basic_last beat %0d: got %b expected %b", k, bus.out_last, k == 7); end
         tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL basic_in_ready beat %0d: got %b expected 0", k, bus.in_ready); end
         tests++; if (bus.frame_done !== 1'b0) begin failed++; $display("FAIL basic_early_done beat %0d: got %b expected 0", k, bus.frame_done); end
         @(negedge sys_clk);
      end
      tests++; if (bus.frame_done !== 1'b1) begin failed++; $display("FAIL basic_frame_done: got %b expected 1", bus.frame_done); end
      tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL basic_ready_on_done: got %b expected 1", bus.in_ready); end
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL basic_valid_after: got %b expected 0", bus.out_valid); end
      @(negedge sys_clk);
      tests++; if (bus.frame_done !== 1'b0) begin failed++; $display("FAIL basic_done_width: got %b expected 0", bus.frame_done); end
   endtask

   task automatic test_backpressure;
      logic [7:0] exp;
      logic       pat;
      int         beat;
      int         cyc;
      fill_pairs(8'd10, 8'd20, 0, 8'h00);
      beat = 0;
      cyc  = 0;
      while (beat < 8 && cyc < 40) begin
         exp = (beat < 4) ? 8'(10 + beat) : 8'(16 + beat);
         pat = (cyc % 3 == 0);
         tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("FAIL bp_valid cycle %0d: got %b expected 1", cyc, bus.out_valid); end
         tests++; if (bus.out_data !== exp) begin failed++; $display("FAIL bp_data cycle %0d: got %0d expected %0d", cyc, bus.out_data, exp); end
         tests++; if (bus.out_last !== (beat == 7)) begin failed++; $display("FAIL bp_last cycle %0d: got %b expected %b", cyc, bus.out_last, beat == 7); end
         tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", cyc, bus.in_ready); end
         bus.out_ready = pat;
         bus.in_valid  = 1'b1;
         bus.low_i     = 8'hEE;
         bus.high_i    = 8'hEF;
         @(negedge sys_clk);
         if (pat) beat++;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tests++; if (beat != 8) begin failed++; $display("FAIL bp_timeout: got %0d beats expected 8", beat); end
      tests++; if (bus.frame_done !== 1'b1) begin failed++; $display("FAIL bp_frame_done: got %b expected 1", bus.frame_done); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp;
      fill_pairs(8'd70, 8'd80, 0, 8'b01_10_00_01);
      for (int k = 0; k < 8; k++) begin
         exp = (k < 4) ? 8'(70 + k) : 8'(76 + k);
         tests++; if (bus.out_data !== exp) begin failed++; $display("FAIL gap_f1_data beat %0d: got %0d expected %0d", k, bus.out_data, exp); end
         @(negedge sys_clk);
      end
      tests++; if (bus.frame_done !== 1'b1) begin failed++; $display("FAIL gap_f1_done: got %b expected 1", bus.frame_done); end
      tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL gap_ready_on_done: got %b expected 1", bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.low_i    = 8'd30;
      bus.high_i   = 8'd40;
      fill_pairs(8'd30, 8'd40, 1, 8'b10_00_01_00);
      for (int k = 0; k < 8; k++) begin
         exp = (k < 4) ? 8'(30 + k) : 8'(36 + k);
         tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("FAIL gap_f2_valid beat %0d: got %b expected 1", k, bus.out_valid); end
         tests++; if (bus.out_data !== exp) begin failed++; $display("FAIL gap_f2_data beat %0d: got %0d expected %0d", k, bus.out_data, exp); end
         tests++; if (bus.out_band !== (k >= 4)) begin failed++; $display("FAIL gap_f2_band beat %0d: got %b expected %b", k, bus.out_band, k >= 4); end
         @(negedge sys_clk);
      end
      tests++; if (bus.frame_done !== 1'b1) begin failed++; $display("FAIL gap_f2_done: got %b expected 1", bus.frame_done); end
   endtask

   task automatic test_mid_reset;
      logic [7:0] exp;
      fill_pairs(8'd90, 8'd100, 0, 8'h00);
      @(negedge sys_clk);
      @(negedge sys_clk);
      tests++; if (bus.out_data !== 8'd92) begin failed++; $display("FAIL mr_pre_data: got %0d expected 92", bus.out_data); end
      #2 sys_rst = 1'b0;
      #1;
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL mr_out_valid: got %b expected 0", bus.out_valid); end
      tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL mr_in_ready: got %b expected 1", bus.in_ready); end
      tests++; if (bus.out_data !== 8'h00) begin failed++; $display("FAIL mr_out_data: got %h expected 00", bus.out_data); end
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL mr_stale_valid: got %b expected 0", bus.out_valid); end
      fill_pairs(8'd50, 8'd60, 0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         exp = (k < 4) ? 8'(50 + k) : 8'(56 + k);
         tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("FAIL mr_valid beat %0d: got %b expected 1", k, bus.out_valid); end
         tests++; if (bus.out_data !== exp) begin failed++; $display("FAIL mr_data beat %0d: got %0d expected %0d", k, bus.out_data, exp); end
         tests++; if (bus.out_last !== (k == 7)) begin failed++; $display("FAIL mr_last beat %0d: got %b expected %b", k, bus.out_last, k == 7); end
         @(negedge sys_clk);
      end
      tests++; if (bus.frame_done !== 1'b1) begin failed++; $display("FAIL mr_frame_done: got %b expected 1", bus.frame_done); end
      tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL mr_valid_after: got %b expected 0", bus.out_valid); end
   endtask

   initial begin
      tests         = 0;
      failed        = 0;
      sys_rst       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.low_i     = '0;
      bus.high_i    = '0;
      bus.out_ready = 1'b1;
      test_reset();
      $display("[TB] test_reset done");
      test_basic();
      $display("[TB] test_basic done");
      test_backpressure();
      $display("[TB] test_backpressure done");
      test_back_to_back();
      $display("[TB] test_back_to_back done");
      test_mid_reset();
      $display("[TB] test_mid_reset done");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/dwt_subband_reorder.md
# dwt_subband_reorder

Downstream consumer of the 1-D two-level DWT core. Accepts the core's per-cycle (low, high) coefficient pairs, buffers one frame of FRAME_LEN pairs, and re-emits it in subband order: all low coefficients, then all high coefficients. Output uses a valid/ready handshake and carries band and last-beat sideband, so the next stage (quantiser/encoder or host capture) sees contiguous subbands.

## Interface
- DATA_W, 8, coefficient width; matches the DWT core's low_o/high_o.
- FRAME_LEN, 16, coefficient pairs per frame; legal range 2..256.
- ADDR_W, 4, buffer index width; must equal ceil(log2(FRAME_LEN)).
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- low_i  in  DATA_W  low-band coefficient from the DWT core.
- high_i  in  DATA_W  high-band coefficient from the DWT core.
- in_valid  in  1  low_i/high_i carry a valid pair this cycle.
- in_ready  out  1  block accepts a pair this cycle.
- out_data  out  DATA_W  reordered coefficient.
- out_band  out  1  0 = low band, 1 = high band.
- out_valid  out  1  out_data/out_band/out_last are valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  final beat of the frame (last high coefficient).
- frame_done  out  1  one-cycle pulse after a frame has fully drained.

## Operation
- Storage: two register arrays lbuf[FRAME_LEN], hbuf[FRAME_LEN] of DATA_W each; contents are not reset.
- Counters: wr_idx (ADDR_W) and rd_idx (ADDR_W), both reset to 0.
- States: FILL, DRAIN_LOW, DRAIN_HIGH; reset state is FILL.
- FILL: in_ready = 1. On in_valid & in_ready, lbuf[wr_idx] <= low_i, hbuf[wr_idx] <= high_i, and wr_idx increments. When the accepted pair has wr_idx == FRAME_LEN-1, wr_idx <= 0 and the next state is DRAIN_LOW.
- DRAIN_LOW: out_valid = 1, out_band = 0, out_data = lbuf[rd_idx]. On out_ready, rd_idx increments. At rd_idx == FRAME_LEN-1 with out_ready, rd_idx <= 0 and the next state is DRAIN_HIGH.
- DRAIN_HIGH: out_valid = 1, out_band = 1, out_data = hbuf[rd_idx], and out_last = (rd_idx == FRAME_LEN-1). On out_ready, rd_idx increments. On the last beat accepted, rd_idx <= 0, the next state is FILL, and frame_done is registered high for exactly the next cycle.
- in_ready = (state == FILL). out_valid = (state != FILL).
- While out_valid = 0, out_data, out_band and out_last are driven to 0.
- No arithmetic on coefficients. Data passes through bit-exact, and signedness is irrelevant.
- Counters never wrap past FRAME_LEN-1; they reset to 0 explicitly at each frame or phase end.

## Timing
- Reset values (sys_rst low): state FILL, in_ready 1, out_valid 0, out_data 0, out_band 0, out_last 0, frame_done 0, wr_idx 0, rd_idx 0. No pair is captured while sys_rst is low.
- Assertion of sys_rst at any time (mid-fill or mid-drain) discards the partial frame asynchronously. The block resumes in FILL with indices 0.
- Latency: the first out_valid beat appears in the cycle after the final input pair is accepted.
- Throughput: one pair per cycle in FILL. In drain, 2*FRAME_LEN beats at one beat per cycle with out_ready held high. A frame cycle is at least 3*FRAME_LEN cycles.
- During drain, in_ready = 0 and in_valid is ignored. Upstream must hold or drop data; the DWT core is stalled or gated externally.
- With out_ready low, out_data, out_band, out_last and rd_idx hold stable. out_valid never deasserts mid-drain.
- in_ready rises in the same cycle frame_done pulses. A pair presented in that cycle is accepted as index 0 of the next frame.
- With out_ready low in FILL, there is no effect.
- The in_valid gap pattern does not matter. wr_idx advances only on an accepted pair.

## Test plan
- Reset check (FRAME_LEN=4): hold sys_rst low with in_valid=1 -> in_ready=1, out_valid=0, out_data=0, frame_done=0, and no capture.
- Basic reorder (FRAME_LEN=4): pairs (L,H) = (10,20),(11,21),(12,22),(13,23) on consecutive cycles, out_ready=1 -> next cycle onward out_data = 10,11,12,13 (band 0), then 20,21,22,23 (band 1). out_last is high only on 23. frame_done pulses the cycle after 23.
- Backpressure: same frame, out_ready toggling 1,0,0,1,... -> no beat lost or duplicated, out_data stable while out_ready=0, in_ready=0 throughout the drain.
- Input gaps plus back-to-back frames: in_valid with random bubbles over two frames (second frame 30..33/40..43) -> second frame is captured correctly, and a pair offered on the frame_done cycle lands at index 0.
- Mid-operation reset: assert sys_rst after 2 drain beats -> outputs go to reset values immediately. A fresh frame of 50..53/60..63 then drains correctly with no stale beats.
